// File: rtl/tri_vertex_ctrl.sv
// Vertex configuration controller: shadow registers committed atomically at frame_start.
// Optional per-frame x drift of the active vertices when TRI_VERTEX_ANIM_EN is defined.
module tri_vertex_ctrl #(
    parameter logic [8:0] X1_INIT = 9'd200,
    parameter logic [8:0] Y1_INIT = 9'd20,
    parameter logic [8:0] X2_INIT = 9'd80,
    parameter logic [8:0] Y2_INIT = 9'd75,
    parameter logic [8:0] X3_INIT = 9'd337,
    parameter logic [8:0] Y3_INIT = 9'd53
`ifdef TRI_VERTEX_ANIM_EN
    ,
    parameter logic signed [3:0] ANIM_DX = 4'sd1
`endif
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
`ifdef TRI_VERTEX_ANIM_EN
    input  logic       anim_en,
`endif
    input  logic       frame_start,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [8:0] wr_data,
    input  logic       commit_req,
    output logic [8:0] x1,
    output logic [8:0] y1,
    output logic [8:0] x2,
    output logic [8:0] y2,
    output logic [8:0] x3,
    output logic [8:0] y3,
    output logic       pending,
    output logic       commit_done,
    output logic       addr_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIRTY   = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam logic [8:0] INIT_VALS [6] = '{X1_INIT, Y1_INIT, X2_INIT, Y2_INIT, X3_INIT, Y3_INIT};

`ifdef TRI_VERTEX_ANIM_EN
    localparam logic [8:0] ANIM_STEP = {{5{ANIM_DX[3]}}, ANIM_DX};
`endif

    state_t     state;
    state_t     state_nxt;
    logic [8:0] shadow [6];
    logic [8:0] active [6];
    logic       wr_fire;
    logic       addr_ok;
    logic       do_commit;

    assign wr_fire   = wr_valid & wr_ready;
    assign addr_ok   = (wr_addr <= 3'd5);
    assign do_commit = (state == PENDING) & frame_start;

    // A frame_start coinciding with commit_req arrives before PENDING, so it is never used.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_fire && addr_ok) state_nxt = DIRTY;
            DIRTY:   if (commit_req) state_nxt = PENDING;
            PENDING: if (frame_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            wr_ready    <= 1'b1;
            pending     <= 1'b0;
            commit_done <= 1'b0;
            addr_err    <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                shadow[i] <= INIT_VALS[i];
                active[i] <= INIT_VALS[i];
            end
        end else begin
            state       <= state_nxt;
            wr_ready    <= (state_nxt != PENDING);
            pending     <= (state_nxt == PENDING);
            commit_done <= do_commit;

            if (wr_fire) begin
                if (addr_ok) begin
                    for (int i = 0; i < 6; i++) begin
                        if (wr_addr == 3'(i)) shadow[i] <= wr_data;
                    end
                end else begin
                    addr_err <= 1'b1;
                end
            end

            // A commit wins over the animation step on the same frame.
            if (do_commit) begin
                for (int i = 0; i < 6; i++) active[i] <= shadow[i];
            end
`ifdef TRI_VERTEX_ANIM_EN
            else if (frame_start && anim_en) begin
                active[0] <= active[0] + ANIM_STEP;
                active[2] <= active[2] + ANIM_STEP;
                active[4] <= active[4] + ANIM_STEP;
            end
`endif
        end
    end

    assign x1 = active[0];
    assign y1 = active[1];
    assign x2 = active[2];
    assign y2 = active[3];
    assign x3 = active[4];
    assign y3 = active[5];

endmodule

// File: tb/tb_tri_vertex_ctrl.sv
// Directed bench for tri_vertex_ctrl: reset, commit timing, blocked writes, illegal addresses.
// Covers the animation step too when built with TRI_VERTEX_ANIM_EN.
module tb_tri_vertex_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N = 1'b0;
    logic       frame_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_addr = 3'd0;
    logic [8:0] wr_data = 9'd0;
    logic       commit_req = 1'b0;
    logic [8:0] x1, y1, x2, y2, x3, y3;
    logic       pending;
    logic       commit_done;
    logic       addr_err;
`ifdef TRI_VERTEX_ANIM_EN
    logic       anim_en = 1'b0;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    tri_vertex_ctrl dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
`ifdef TRI_VERTEX_ANIM_EN
        .anim_en    (anim_en),
`endif
        .frame_start(frame_start),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit_req (commit_req),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .x3         (x3),
        .y3         (y3),
        .pending    (pending),
        .commit_done(commit_done),
        .addr_err   (addr_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Inputs change on the falling edge; outputs are observed on the following falling edge.
    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        frame_start = 1'b0;
        wr_valid = 1'b0;
        commit_req = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic host_write(input logic [2:0] a, input logic [8:0] d);
        wr_valid = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({x1, y1, x2, y2, x3, y3} !== {9'd200, 9'd20, 9'd80, 9'd75, 9'd337, 9'd53}) begin
            tests_failed++;
            $display("[TB] FAIL reset_vertices: got %0d,%0d,%0d,%0d,%0d,%0d expected 200,20,80,75,337,53",
                     x1, y1, x2, y2, x3, y3);
        end
        tests_run++;
        if ({wr_ready, pending, commit_done, addr_err} !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got ready/pend/done/err=%b expected 1000",
                     {wr_ready, pending, commit_done, addr_err});
        end
        RESET_N = 1'b1;
        tick();
        tests_run++;
        if ({x1, wr_ready, pending} !== {9'd200, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL after_release: got x1=%0d ready=%b pend=%b expected 200 1 0",
                     x1, wr_ready, pending);
        end
    endtask

    task automatic test_commit_latency();
        int done_count = 0;
        bit held = 1'b1;
        do_reset();
        host_write(3'd0, 9'd100);
        pulse_commit();
        tests_run++;
        if ({pending, wr_ready, x1} !== {1'b1, 1'b0, 9'd200}) begin
            tests_failed++;
            $display("[TB] FAIL armed: got pend=%b ready=%b x1=%0d expected 1 0 200",
                     pending, wr_ready, x1);
        end
        for (int i = 0; i < 39; i++) begin
            tick();
            if (x1 !== 9'd200 || pending !== 1'b1) held = 1'b0;
            if (commit_done === 1'b1) done_count++;
        end
        tests_run++;
        if (!held) begin
            tests_failed++;
            $display("[TB] FAIL wait_hold: got held=%b expected 1 (x1 200, pending 1)", held);
        end
        pulse_frame();
        if (commit_done === 1'b1) done_count++;
        tests_run++;
        if ({x1, commit_done, pending, wr_ready} !== {9'd100, 1'b1, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL commit_edge: got x1=%0d done=%b pend=%b ready=%b expected 100 1 0 1",
                     x1, commit_done, pending, wr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (commit_done === 1'b1) done_count++;
        end
        tests_run++;
        if (done_count != 1) begin
            tests_failed++;
            $display("[TB] FAIL done_pulses: got %0d expected 1", done_count);
        end
    endtask

    task automatic test_held_write();
        bit blocked = 1'b1;
        do_reset();
        host_write(3'd2, 9'd90);
        pulse_commit();
        wr_valid = 1'b1;
        wr_addr = 3'd2;
        wr_data = 9'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_ready !== 1'b0 || x2 !== 9'd80) blocked = 1'b0;
        end
        tests_run++;
        if (!blocked) begin
            tests_failed++;
            $display("[TB] FAIL pending_block: got blocked=%b expected 1", blocked);
        end
        pulse_frame();
        tests_run++;
        if ({x2, wr_ready} !== {9'd90, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL held_commit: got x2=%0d ready=%b expected 90 1", x2, wr_ready);
        end
        tick();
        wr_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({x2, pending} !== {9'd90, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL shadow_only: got x2=%0d pend=%b expected 90 0", x2, pending);
        end
        pulse_commit();
        tick();
        pulse_frame();
        tests_run++;
        if (x2 !== 9'd99) begin
            tests_failed++;
            $display("[TB] FAIL late_write: got x2=%0d expected 99", x2);
        end
    endtask

    task automatic test_addr_err();
        do_reset();
        host_write(3'd7, 9'd55);
        tests_run++;
        if ({addr_err, x1, y1, x2, y2, x3, y3} !==
            {1'b1, 9'd200, 9'd20, 9'd80, 9'd75, 9'd337, 9'd53}) begin
            tests_failed++;
            $display("[TB] FAIL addr7: got err=%b x1=%0d y3=%0d expected 1 200 53", addr_err, x1, y3);
        end
        host_write(3'd6, 9'd1);
        pulse_commit();
        tick();
        tests_run++;
        if ({addr_err, pending, wr_ready} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL stays_idle: got err/pend/ready=%b expected 101",
                     {addr_err, pending, wr_ready});
        end
        pulse_frame();
        tests_run++;
        if ({commit_done, addr_err, x1, y1} !== {1'b0, 1'b1, 9'd200, 9'd20}) begin
            tests_failed++;
            $display("[TB] FAIL idle_frame: got done=%b err=%b x1=%0d y1=%0d expected 0 1 200 20",
                     commit_done, addr_err, x1, y1);
        end
    endtask

    task automatic test_same_cycle_frame();
        do_reset();
        host_write(3'd5, 9'd7);
        commit_req = 1'b1;
        frame_start = 1'b1;
        tick();
        commit_req = 1'b0;
        frame_start = 1'b0;
        tick();
        tests_run++;
        if ({y3, pending, commit_done} !== {9'd53, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL frame_with_req: got y3=%0d pend=%b done=%b expected 53 1 0",
                     y3, pending, commit_done);
        end
        tick();
        pulse_frame();
        tests_run++;
        if ({y3, commit_done} !== {9'd7, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL next_frame: got y3=%0d done=%b expected 7 1", y3, commit_done);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        host_write(3'd1, 9'd11);
        wr_valid = 1'b1;
        wr_addr = 3'd3;
        wr_data = 9'd33;
        commit_req = 1'b1;
        tick();
        wr_valid = 1'b0;
        commit_req = 1'b0;
        pulse_commit();
        pulse_frame();
        tests_run++;
        if ({y1, y2, x1, commit_done} !== {9'd11, 9'd33, 9'd200, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL write_with_commit: got y1=%0d y2=%0d x1=%0d done=%b expected 11 33 200 1",
                     y1, y2, x1, commit_done);
        end
    endtask

    task automatic test_reset_in_pending();
        do_reset();
        host_write(3'd4, 9'd400);
        host_write(3'd7, 9'd3);
        pulse_commit();
        RESET_N = 1'b0;
        #1;
        tests_run++;
        if ({pending, wr_ready, addr_err, commit_done, x3} !== {4'b0100, 9'd337}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got pend/ready/err/done=%b x3=%0d expected 0100 337",
                     {pending, wr_ready, addr_err, commit_done}, x3);
        end
        tick();
        RESET_N = 1'b1;
        tick();
        pulse_frame();
        tests_run++;
        if ({x3, commit_done} !== {9'd337, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_drops_commit: got x3=%0d done=%b expected 337 0", x3, commit_done);
        end
    endtask

`ifdef TRI_VERTEX_ANIM_EN
    task automatic test_anim();
        do_reset();
        host_write(3'd4, 9'd511);
        pulse_commit();
        anim_en = 1'b1;
        pulse_frame();
        tests_run++;
        if ({x1, x2, x3} !== {9'd200, 9'd80, 9'd511}) begin
            tests_failed++;
            $display("[TB] FAIL anim_commit_priority: got %0d,%0d,%0d expected 200,80,511", x1, x2, x3);
        end
        pulse_frame();
        tests_run++;
        if ({x1, x2, x3, y1} !== {9'd201, 9'd81, 9'd0, 9'd20}) begin
            tests_failed++;
            $display("[TB] FAIL anim_wrap: got %0d,%0d,%0d y1=%0d expected 201,81,0 20", x1, x2, x3, y1);
        end
        anim_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_commit_latency();
        test_held_write();
        test_addr_err();
        test_same_cycle_frame();
        test_back_to_back();
        test_reset_in_pending();
`ifdef TRI_VERTEX_ANIM_EN
        test_anim();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tri_vertex_ctrl.md
# tri_vertex_ctrl

Configuration controller for the triangle renderer's point-in-triangle tester. It holds the three active vertex coordinates that feed the tester. A host writes new coordinates into shadow registers through a valid/ready port. The controller commits them atomically at the next frame boundary, so a triangle never tears mid-frame.

## Interface

**Parameters**
- X1_INIT, 200, reset value of vertex 1 x (9-bit)
- Y1_INIT, 20, reset value of vertex 1 y
- X2_INIT, 80, reset value of vertex 2 x
- Y2_INIT, 75, reset value of vertex 2 y
- X3_INIT, 337, reset value of vertex 3 x
- Y3_INIT, 53, reset value of vertex 3 y

**Ports**
- CLOCK_50  in  1  the single clock; all logic in this domain
- RESET_N  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse when the scan counters wrap (cx==1585 and cy==525)
- wr_valid  in  1  host write request
- wr_ready  out  1  controller can accept a write
- wr_addr  in  3  0..5 select x1,y1,x2,y2,x3,y3; 6 and 7 are illegal
- wr_data  in  9  coordinate, in tester units (cx/4, cy/2)
- commit_req  in  1  one-cycle pulse requesting a commit of the shadow registers
- x1,y1,x2,y2,x3,y3  out  9 each  active vertices driven to the tester
- pending  out  1  a commit is armed and waiting for frame_start
- commit_done  out  1  one-cycle pulse, registered
- addr_err  out  1  sticky flag, set by a handshake to an illegal address

## Operation

- Reset values:
  - Active registers and shadow registers = *_INIT.
  - State IDLE.
  - wr_ready=1, pending=0, commit_done=0, addr_err=0.
- A write handshake occurs on a cycle with wr_valid & wr_ready.
  - Legal address: shadow[wr_addr] <= wr_data.
  - Illegal address: data is dropped, addr_err <= 1, and the state does not change.
- FSM states:
  - **IDLE**: the shadow equals the active set. A legal write moves to DIRTY. commit_req is ignored, so no commit_done is produced.
  - **DIRTY**: writes are accepted. commit_req moves to PENDING.
  - **PENDING**: wr_ready=0 and pending=1. When frame_start is seen, all six active registers load from shadow in the same edge, commit_done <= 1, and the state returns to IDLE.
- Simultaneous events:
  - A legal write and commit_req in the same DIRTY cycle: the write lands in shadow and is included in the commit. State goes to PENDING.
  - commit_req and frame_start in the same cycle: that frame_start is not used. The commit waits for the next frame_start.
  - commit_req arriving while already PENDING is ignored.
- Active outputs change only on a commit, or through the configured animation described below.
- Asserting RESET_N low at any point, including PENDING, immediately restores all reset values. No commit_done is produced.

## Timing

- A write is visible in shadow 1 cycle after the handshake. It is never visible on the outputs before a commit.
- Commit latency: the active outputs and commit_done update on the edge that samples frame_start in PENDING. They are visible 1 cycle after the frame_start pulse.
- wr_ready is a registered state decode. It drops on the cycle after commit_req is accepted and rises on the cycle after the commit.
- The worst-case commit wait is one frame: 1586 × 526 cycles.

## Configuration

- **TRI_VERTEX_ANIM_EN**
  - Defined:
    - Adds input port anim_en (1 bit) and signed parameter ANIM_DX (4 bits, default 1).
    - On each frame_start seen in IDLE or DIRTY with anim_en=1, x1, x2 and x3 each get += ANIM_DX, modulo 512, with wrap-around.
    - Shadow registers are not modified.
    - In PENDING, a commit takes priority: shadow loads and no offset is added that frame.
  - Undefined: no anim_en port, and the active vertices change only on a commit.

## Test plan

- Release reset -> outputs read 200,20,80,75,337,53; wr_ready=1; pending=0.
- Write x1=100 and commit_req, then frame_start 40 cycles later -> x1 stays 200 until 1 cycle after frame_start, then 100; exactly one commit_done pulse.
- In PENDING, hold wr_valid with addr 2 -> wr_ready=0 and no handshake; after the commit, the write completes and goes to shadow only.
- Write to addr 7 with data 55 -> addr_err=1 and stays set; state remains IDLE; outputs unchanged.
- commit_req on the same cycle as frame_start -> no update at that frame; update 1 cycle after the next frame_start.
- With TRI_VERTEX_ANIM_EN, ANIM_DX=1, anim_en=1, x3=511 -> after frame_start, x3=0, x1=201, x2=81.
